// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with LANE-bit shifts and frame counter
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int LANE  = 1,
    parameter int CNT_W = $clog2(WIDTH / LANE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic [LANE-1:0]  ser_in_lsb,
    input  logic [LANE-1:0]  ser_in_msb,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic [LANE-1:0]  ser_out_msb,
    output logic [LANE-1:0]  ser_out_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(WIDTH / LANE - 1);

    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             frame_done_q;
    logic [LANE-1:0]  fill_lsb;
    logic [LANE-1:0]  fill_msb;
    logic             do_shift;

    // Rotation recirculates the lane falling off the opposite end.
    assign fill_lsb = rot ? data_q[WIDTH-1 -: LANE] : ser_in_lsb;
    assign fill_msb = rot ? data_q[LANE-1:0]        : ser_in_msb;
    assign do_shift = en && ((mode == MODE_LEFT) || (mode == MODE_RIGHT));

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else if (en && (mode == MODE_LOAD)) begin
            data_q       <= par_in;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else if (do_shift) begin
            if (mode == MODE_LEFT) begin
                data_q <= {data_q[WIDTH-LANE-1:0], fill_lsb};
            end else begin
                data_q <= {fill_msb, data_q[WIDTH-1:LANE]};
            end
            if (cnt_q == FRAME_LAST) begin
                cnt_q        <= '0;
                frame_done_q <= 1'b1;
            end else begin
                cnt_q        <= cnt_q + 1'b1;
                frame_done_q <= 1'b0;
            end
        end else begin
            frame_done_q <= 1'b0;
        end
    end

    logic unused_hold;
    assign unused_hold = (mode == MODE_HOLD);

    assign par_out     = data_q;
    assign ser_out_msb = data_q[WIDTH-1 -: LANE];
    assign ser_out_lsb = data_q[LANE-1:0];
    assign shift_cnt   = cnt_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg (LANE=1 and LANE=2 instances)
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       rot = 1'b0;
    logic [1:0] sin_l = 2'b00;
    logic [1:0] sin_m = 2'b00;
    logic [7:0] par_in = 8'h00;

    logic [7:0] p1, p2;
    logic       som1, sol1;
    logic [1:0] som2, sol2;
    logic [3:0] cnt1;
    logic [2:0] cnt2;
    logic       fd1, fd2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .LANE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
        .ser_in_lsb(sin_l[0]), .ser_in_msb(sin_m[0]), .par_in(par_in),
        .par_out(p1), .ser_out_msb(som1), .ser_out_lsb(sol1),
        .shift_cnt(cnt1), .frame_done(fd1)
    );

    univ_shift_reg #(.WIDTH(8), .LANE(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
        .ser_in_lsb(sin_l), .ser_in_msb(sin_m), .par_in(par_in),
        .par_out(p2), .ser_out_msb(som2), .ser_out_lsb(sol2),
        .shift_cnt(cnt2), .frame_done(fd2)
    );

    typedef struct {
        bit         which;
        logic [7:0] par;
        int         cnt;
        bit         fd;
        string      name;
    } exp_t;

    exp_t sb[$];

    // Inputs applied on the falling edge; expectation covers the state after the next rising edge.
    task automatic step(input bit w, input bit r, input bit e, input logic [1:0] m,
                        input bit ro, input logic [1:0] sl, input logic [1:0] sm,
                        input logic [7:0] p, input logic [7:0] ep, input int ec,
                        input bit ef, input string nm);
        exp_t x;
        rst = r; en = e; mode = m; rot = ro; sin_l = sl; sin_m = sm; par_in = p;
        x.which = w; x.par = ep; x.cnt = ec; x.fd = ef; x.name = nm;
        sb.push_back(x);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                tests++;
                if (!x.which) begin
                    if (p1 !== x.par || int'(cnt1) != x.cnt || fd1 !== x.fd
                        || som1 !== x.par[7] || sol1 !== x.par[0]) begin
                        fails++;
                        $display("FAIL %s: got par=%h cnt=%0d fd=%b som=%b sol=%b, want par=%h cnt=%0d fd=%b",
                                 x.name, p1, cnt1, fd1, som1, sol1, x.par, x.cnt, x.fd);
                    end
                end else begin
                    if (p2 !== x.par || int'(cnt2) != x.cnt || fd2 !== x.fd
                        || som2 !== x.par[7:6] || sol2 !== x.par[1:0]) begin
                        fails++;
                        $display("FAIL %s: got par=%h cnt=%0d fd=%b som=%b sol=%b, want par=%h cnt=%0d fd=%b",
                                 x.name, p2, cnt2, fd2, som2, sol2, x.par, x.cnt, x.fd);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [7:0] ROTL [8] = '{8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E, 8'h3C};
    localparam logic [7:0] ROTR [8] = '{8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0, 8'h78, 8'h3C};
    localparam logic [7:0] ONES [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    initial begin : driver
        @(negedge clk);
        // T1: serial-in left shift, single-cycle frame pulse
        step(0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, "t1_reset");
        step(0, 0, 1, 2'b01, 0, 2'b01, 2'b00, 8'h00, 8'h01, 1, 0, "t1_sl1");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h02, 2, 0, "t1_sl2");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h04, 3, 0, "t1_sl3");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h08, 4, 0, "t1_sl4");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h10, 5, 0, "t1_sl5");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h20, 6, 0, "t1_sl6");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h40, 7, 0, "t1_sl7");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h80, 0, 1, "t1_frame");
        step(0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 8'h00, 8'h80, 0, 0, "t1_pulse_end");
        // T2: load, shift right, rotates
        step(0, 0, 1, 2'b11, 1, 2'b00, 2'b00, 8'hA5, 8'hA5, 0, 0, "t2_load");
        step(0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 8'h00, 8'h52, 1, 0, "t2_sr");
        step(0, 0, 1, 2'b10, 1, 2'b00, 2'b01, 8'h00, 8'h29, 2, 0, "t2_rotr");
        step(0, 0, 1, 2'b01, 1, 2'b01, 2'b00, 8'h00, 8'h52, 3, 0, "t2_rotl");
        // T3: enable low holds everything
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 2'b01, 0, 2'b01, 2'b01, 8'hFF, 8'h52, 3, 0, "t3_en_low");
        // T4: reset aborts a partial frame
        step(0, 0, 1, 2'b01, 0, 2'b01, 2'b00, 8'h00, 8'hA5, 4, 0, "t4_pre");
        step(0, 1, 1, 2'b11, 0, 2'b00, 2'b00, 8'hFF, 8'h00, 0, 0, "t4_rst_a");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 2'b01, 0, 2'b01, 2'b00, 8'h00, ONES[i], i + 1, 0, "t4_part");
        step(0, 1, 1, 2'b01, 0, 2'b01, 2'b00, 8'h00, 8'h00, 0, 0, "t4_rst_b");
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 2'b01, 0, 2'b01, 2'b00, 8'h00, ONES[i], (i + 1) % 8, i == 7, "t4_full");
        step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'hFE, 1, 0, "t4_next");
        // T5: load on the would-be frame-completing cycle wins
        step(0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, "t5_rst");
        for (int i = 0; i < 7; i++)
            step(0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 8'h00, 8'h00, i + 1, 0, "t5_shift");
        step(0, 0, 1, 2'b11, 0, 2'b00, 2'b00, 8'h3C, 8'h3C, 0, 0, "t5_load");
        step(0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 8'h00, 8'h3C, 0, 0, "t5_no_pulse");
        // Back-to-back rotate frames in opposite directions, no dead cycle
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 2'b01, 1, 2'b00, 2'b00, 8'h00, ROTL[i], (i + 1) % 8, i == 7, "b2b_rotl");
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 2'b10, 1, 2'b00, 2'b00, 8'h00, ROTR[i], (i + 1) % 8, i == 7, "b2b_rotr");
        // T6: two-bit lanes on the second instance
        step(1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, "t6_reset");
        step(1, 0, 1, 2'b01, 0, 2'b11, 2'b00, 8'h00, 8'h03, 1, 0, "t6_sl1");
        step(1, 0, 1, 2'b01, 0, 2'b11, 2'b00, 8'h00, 8'h0F, 2, 0, "t6_sl2");
        step(1, 0, 1, 2'b01, 0, 2'b11, 2'b00, 8'h00, 8'h3F, 3, 0, "t6_sl3");
        step(1, 0, 1, 2'b01, 0, 2'b11, 2'b00, 8'h00, 8'hFF, 0, 1, "t6_frame");
        step(1, 0, 0, 2'b01, 0, 2'b11, 2'b00, 8'h00, 8'hFF, 0, 0, "t6_pulse_end");
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
